// File: rtl/result_quantizer_if.sv
// ---------------------------------------------------------------------------
// result_quantizer_if
// Accumulator result stream into result_quantizer.
//   acc_in    : signed accumulator result (ACC_W bits)
//   acc_valid : acc_in valid
//   acc_ready : quantizer accepts acc_in this cycle
// Modports: master = upstream datapath, slave = quantizer.
// ---------------------------------------------------------------------------
interface result_quantizer_if #(
  parameter int ACC_W = 20
);
  logic signed [ACC_W-1:0] acc_in;
  logic                    acc_valid;
  logic                    acc_ready;

  modport master (output acc_in, output acc_valid, input acc_ready);
  modport slave  (input  acc_in, input  acc_valid, output acc_ready);
endinterface

// File: rtl/result_quantizer.sv
// ---------------------------------------------------------------------------
// result_quantizer
// Requantizes signed accumulator results to unsigned 8-bit bytes, packs them
// into 16-byte lines held in two ping-pong buffers, and streams each frame to
// the output store as one unbroken byte-per-cycle StartOut/ResultOut burst.
//
// Ports:
//   clock, reset_n          : clock, async active-low reset
//   frame_start             : 1-cycle pulse, latches frame_lines and shift
//   frame_lines [LINES_W]   : number of 16-byte lines in the frame
//   shift [4]               : arithmetic right shift for requantization
//   acc (slave modport)     : acc_in / acc_valid / acc_ready stream
//   StartOut, ResultOut[8]  : to store StartIn / ResultIn
//   busy                    : frame in progress
//   frame_done              : 1-cycle pulse at frame end
//   underrun                : sticky until next frame_start; frame aborted
//
// Build option: define QUANT_ROUND_EN for round-half-up requantization;
// otherwise a plain truncating arithmetic shift is used.
// ---------------------------------------------------------------------------
module result_quantizer #(
  parameter int ACC_W   = 20,
  parameter int LINES_W = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [LINES_W-1:0] frame_lines,
  input  logic [3:0]         shift,
  result_quantizer_if.slave  acc,
  output logic               StartOut,
  output logic [7:0]         ResultOut,
  output logic               busy,
  output logic               frame_done,
  output logic               underrun
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]           r_state;
  logic [LINES_W-1:0]   r_lines;
  logic [3:0]           r_shift;
  logic [LINES_W+3:0]   r_acc_cnt;    // results accepted this frame
  logic [4:0]           r_wr_cnt;     // [4] = fill buffer, [3:0] = byte slot
  logic [1:0]           r_full;
  logic                 r_q_vld;
  logic [7:0]           r_q_byte;
  logic                 r_rd_sel;
  logic [3:0]           r_rd_idx;     // 0 means "at a line boundary"
  logic [LINES_W-1:0]   r_out_lines;
  logic [1:0][15:0][7:0] r_buf;

  // ---- requantize ----------------------------------------------------------
  // Computed one bit wider than the accumulator so the rounding add cannot wrap.
  logic signed [ACC_W:0] w_ext, w_sum, w_shr;
  logic [7:0]            w_qbyte;

  assign w_ext = {acc.acc_in[ACC_W-1], acc.acc_in};
`ifdef QUANT_ROUND_EN
  logic signed [ACC_W:0] w_rnd;
  assign w_rnd = (r_shift == 4'd0) ? '0 : ((ACC_W+1)'(1) << (r_shift - 4'd1));
  assign w_sum = w_ext + w_rnd;
`else
  assign w_sum = w_ext;
`endif
  assign w_shr   = w_sum >>> r_shift;
  assign w_qbyte = w_shr[ACC_W]         ? 8'h00 :
                   (|w_shr[ACC_W-1:8])  ? 8'hFF : w_shr[7:0];

  // ---- accept --------------------------------------------------------------
  // Target buffer follows the accept count's line parity. A buffer whose last
  // byte is being emitted this cycle may take a new result: the write lands a
  // cycle later, after the read. Without this, sustained input underruns.
  logic w_tgt, w_drain_last, w_ready, w_accept;
  assign w_tgt        = r_acc_cnt[4];
  assign w_drain_last = (r_state == S_STREAM) && (r_rd_idx == 4'hF);
  assign w_ready      = ((r_state == S_FILL) || (r_state == S_STREAM)) &&
                        (r_acc_cnt < {r_lines, 4'b0000}) &&
                        (!r_full[w_tgt] || (w_drain_last && (r_rd_sel == w_tgt)));
  assign w_accept     = w_ready && acc.acc_valid;
  assign acc.acc_ready = w_ready;

  // Line storage carries no reset: occupancy is tracked by r_full.
  always_ff @(posedge clock) begin
    if (r_q_vld) r_buf[r_wr_cnt[4]][r_wr_cnt[3:0]] <= r_q_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lines     <= '0;
      r_shift     <= '0;
      r_acc_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_full      <= '0;
      r_q_vld     <= 1'b0;
      r_q_byte    <= '0;
      r_rd_sel    <= 1'b0;
      r_rd_idx    <= '0;
      r_out_lines <= '0;
      StartOut    <= 1'b0;
      ResultOut   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      r_q_vld    <= w_accept;
      r_q_byte   <= w_qbyte;
      if (w_accept) r_acc_cnt <= r_acc_cnt + 1'b1;

      // Write side: buffer full on its 16th byte, then filling toggles.
      if (r_q_vld) begin
        r_wr_cnt <= r_wr_cnt + 5'd1;
        if (r_wr_cnt[3:0] == 4'hF) r_full[r_wr_cnt[4]] <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            underrun <= 1'b0;
            if (frame_lines == '0) begin
              frame_done <= 1'b1;
            end else begin
              r_state     <= S_FILL;
              busy        <= 1'b1;
              r_lines     <= frame_lines;
              r_shift     <= shift;
              r_acc_cnt   <= '0;
              r_wr_cnt    <= '0;
              r_full      <= '0;
              r_q_vld     <= 1'b0;
              r_rd_sel    <= 1'b0;
              r_rd_idx    <= '0;
              r_out_lines <= '0;
            end
          end
        end
        S_FILL: begin
          if (r_full[0]) begin
            StartOut  <= 1'b1;
            ResultOut <= r_buf[0][0];
            r_rd_idx  <= 4'd1;
            r_state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_rd_idx != 4'd0) begin
            ResultOut <= r_buf[r_rd_sel][r_rd_idx];
            r_rd_idx  <= r_rd_idx + 4'd1;
            if (r_rd_idx == 4'hF) begin
              r_full[r_rd_sel] <= 1'b0;
              r_rd_sel         <= ~r_rd_sel;
              r_out_lines      <= r_out_lines + 1'b1;
            end
          end else if (r_out_lines == r_lines) begin
            StartOut  <= 1'b0;
            ResultOut <= '0;
            r_state   <= S_FINISH;
          end else if (r_full[r_rd_sel]) begin
            ResultOut <= r_buf[r_rd_sel][0];
            r_rd_idx  <= 4'd1;
          end else begin
            // Store rewinds its address on any StartOut gap: abort the frame.
            StartOut  <= 1'b0;
            ResultOut <= '0;
            underrun  <= 1'b1;
            r_state   <= S_FINISH;
          end
        end
        default: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_result_quantizer.sv
module tb_result_quantizer;
  localparam int ACC_W   = 20;
  localparam int LINES_W = 12;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               frame_start;
  logic [LINES_W-1:0] frame_lines;
  logic [3:0]         shift;
  logic               StartOut;
  logic [7:0]         ResultOut;
  logic               busy, frame_done, underrun;

  result_quantizer_if #(.ACC_W(ACC_W)) acc_if ();

  result_quantizer #(.ACC_W(ACC_W), .LINES_W(LINES_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .frame_start(frame_start), .frame_lines(frame_lines), .shift(shift),
    .acc(acc_if),
    .StartOut(StartOut), .ResultOut(ResultOut),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int run_len = 0, last_run = 0, fall_cyc = 0, done_cyc = 0, done_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: pops the scoreboard whenever the store would capture a byte.
  always @(negedge clock) begin
    logic [7:0] e;
    if (StartOut) begin
      run_len++;
      if (exp_q.size() == 0) begin
        check("unexpected_byte", ResultOut, -1);
      end else begin
        e = exp_q.pop_front();
        check("stream_byte", ResultOut, e);
      end
    end else begin
      if (run_len != 0) begin
        last_run = run_len;
        fall_cyc = cyc;
      end
      run_len = 0;
      check("idle_result_zero", ResultOut, 0);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_frame(input int lines, input int sh);
    frame_lines = LINES_W'(lines);
    shift       = 4'(sh);
    frame_start = 1'b1;
    @(posedge clock); #1;
    frame_start = 1'b0;
  endtask

  task automatic push(input int v, input int e, input bit exp_out);
    bit ok = 0;
    acc_if.acc_valid = 1'b1;
    acc_if.acc_in    = ACC_W'(v);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (acc_if.acc_ready) begin ok = 1; break; end
    end
    if (ok) begin
      if (exp_out) exp_q.push_back(8'(e));
      @(posedge clock); #1;
    end else begin
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_done(input int d0);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) check("frame_done_timeout", 0, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic frame_end(input string nm, input int d0, input int exp_run);
    wait_done(d0);
    check({nm, "_run_len"}, last_run, exp_run);
    check({nm, "_done_after_fall"}, done_cyc - fall_cyc, 1);
    check({nm, "_done_pulses"}, done_cnt - d0, 1);
    check({nm, "_busy_clear"}, busy, 0);
    check({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit ok;
    reset_n = 1'b0; frame_start = 1'b0; frame_lines = '0; shift = '0;
    acc_if.acc_valid = 1'b0; acc_if.acc_in = '0;
    repeat (3) @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_StartOut", StartOut, 0);
    check("rst_ResultOut", ResultOut, 0);
    check("rst_busy", busy, 0);
    check("rst_acc_ready", acc_if.acc_ready, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    @(posedge clock); #1;

    // 1-line frame, identity quantization
    d0 = done_cnt;
    start_frame(1, 0);
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 16; i++) push(i, i, 1);
    acc_if.acc_valid = 1'b0;
    frame_end("line1", d0, 16);

    // saturation, shift 4
    d0 = done_cnt;
    start_frame(1, 4);
    push(-37, 8'h00, 1);
    push(4095, 8'hFF, 1);
    push(32'h7F0, 8'h7F, 1);
    for (int i = 3; i < 16; i++) push(i * 16, i, 1);
    acc_if.acc_valid = 1'b0;
    frame_end("sat", d0, 16);

    // rounding, shift 2: 6 -> 2 rounded, 1 truncated
    d0 = done_cnt;
    start_frame(1, 2);
`ifdef QUANT_ROUND_EN
    push(6, 2, 1);
`else
    push(6, 1, 1);
`endif
    for (int i = 1; i < 16; i++) push(i * 4, i, 1);
    acc_if.acc_valid = 1'b0;
    frame_end("round", d0, 16);

    // 4-line frame, sustained input: 64 gapless bytes
    d0 = done_cnt;
    start_frame(4, 0);
    for (int i = 0; i < 64; i++) push(i + 7, i + 7, 1);
    @(negedge clock);
    check("ready_low_after_64", acc_if.acc_ready, 0);
    @(negedge clock);
    check("ready_still_low", acc_if.acc_ready, 0);
    acc_if.acc_valid = 1'b0;
    frame_end("line4", d0, 64);

    // 3-line frame, input stalls after 20 results -> underrun
    d0 = done_cnt;
    start_frame(3, 0);
    for (int i = 0; i < 20; i++) push(i + 50, i + 50, i < 16);
    acc_if.acc_valid = 1'b0;
    repeat (20) @(posedge clock); #1;
    acc_if.acc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("underrun_refused", acc_if.acc_ready, 0);
    end
    acc_if.acc_valid = 1'b0;
    check("underrun_flag", underrun, 1);
    frame_end("underrun", d0, 16);
    check("underrun_sticky", underrun, 1);

    // zero-line frame
    @(posedge clock); #1;
    d0 = done_cnt;
    start_frame(0, 0);
    check("zero_done_pulse", frame_done, 1);
    check("zero_busy", busy, 0);
    check("zero_underrun_cleared", underrun, 0);
    @(posedge clock); #1;
    check("zero_done_single", frame_done, 0);
    check("zero_stays_idle", acc_if.acc_ready, 0);

    // reset during line 1 of a 2-line frame
    start_frame(2, 0);
    for (int i = 0; i < 16; i++) push(i + 100, i + 100, 1);
    acc_if.acc_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (StartOut) begin ok = 1; break; end
    end
    check("reset_test_stream_started", ok, 1);
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_StartOut", StartOut, 0);
    check("midrst_busy", busy, 0);
    check("midrst_acc_ready", acc_if.acc_ready, 0);
    check("midrst_underrun", underrun, 0);
    exp_q.delete();
    @(negedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // normal frame after reset
    d0 = done_cnt;
    start_frame(1, 3);
    for (int i = 0; i < 16; i++) push(i * 8, i, 1);
    acc_if.acc_valid = 1'b0;
    frame_end("post_reset", d0, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/result_quantizer.md
Name: result_quantizer

Overview:
- Final compute-to-memory stage, directly upstream of the output store.
- Takes signed wide accumulator results from the datapath, requantizes each one to 8 bits, and packs them into 16-byte lines.
- Drives the store's StartIn/ResultIn pair as one unbroken byte-per-cycle stream per frame. The store drops its address back to base whenever StartIn falls, so StartOut must never gap mid-frame.
- Uses ping-pong line buffers so upstream can run at 1 result/cycle.

Parameters:
- ACC_W, 20, accumulator width (signed two's complement)
- LINES_W, 12, width of the frame line-count input

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle pulse; latches frame_lines and shift, begins a frame
- frame_lines  input  LINES_W  number of 16-byte lines in the frame
- shift  input  4  right-shift amount for requantization
- acc_in  input  ACC_W  signed accumulator result
- acc_valid  input  1  acc_in valid
- acc_ready  output  1  block accepts acc_in this cycle
- StartOut  output  1  to store StartIn; high continuously while streaming
- ResultOut  output  8  to store ResultIn; one byte per cycle
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse at frame end
- underrun  output  1  sticky until next frame_start; frame aborted because the next line was not ready

Behaviour:
- Reset, asynchronous: all outputs 0; FSM IDLE; buffers marked empty; all counters 0.
- FSM states: IDLE, FILL, STREAM, FINISH.
  - IDLE -> FILL on frame_start when frame_lines != 0.
  - frame_start with frame_lines == 0: frame_done pulses on the next cycle; state stays IDLE; busy stays 0.
  - frame_start while busy is ignored.
- Accept rule: a transfer occurs when acc_valid & acc_ready. acc_ready = busy & (accepted < frame_lines*16) & (a fill buffer is not full).
- Quantize, one registered stage:
  - Arithmetic right shift by shift.
  - Saturate to unsigned 0..255: negative -> 0; >255 -> 255.
  - The result is written to the current fill buffer one cycle after acceptance.
- Byte order: the first byte of a line is streamed first and lands in store bits [127:120]; byte 15 lands in [7:0].
- Line complete: a buffer becomes full when its 16th byte is written. Filling then toggles to the other buffer.
- FILL -> STREAM once buffer A is full. StartOut and ResultOut are registered and rise at the 2nd clock edge after the edge that accepted the 16th accumulator.
- STREAM:
  - Emits 16 consecutive bytes per line.
  - A buffer is marked empty in the cycle its byte 15 is emitted.
  - At a line boundary, if the other buffer is full, streaming continues with no gap cycle.
- Underrun: at a line boundary, if more lines remain and the other buffer is not full:
  - StartOut drops the next cycle.
  - underrun is set.
  - acc_ready goes low; remaining input is not accepted.
  - Go to FINISH.
- Normal end: after the byte 15 of line frame_lines is emitted, StartOut drops the next cycle; go to FINISH.
- FINISH: frame_done pulses for one cycle; busy clears; go to IDLE.
- ResultOut is 0x00 whenever StartOut = 0.
- Simultaneous: a buffer may fill in the same cycle the other drains its last byte; both actions take effect.
- Arithmetic: the shifted and rounded value is computed at ACC_W+1 bits, so the rounding add never overflows before saturation.

Optional Feature:
- QUANT_ROUND_EN
  - Defined: round half up. Add 1<<(shift-1) before shifting when shift > 0; no add when shift = 0.
  - Undefined: plain truncating arithmetic shift. No adder is instantiated.

Test Plan:
- Reset mid-STREAM: reset_n low for 1 cycle during line 1 -> StartOut=0, busy=0, acc_ready=0, underrun=0 immediately; a subsequent frame runs normally.
- 1-line frame, shift=0, acc_in = 0..15 back-to-back -> StartOut high exactly 16 cycles, ResultOut 0x00..0x0F in order, frame_done 1 cycle after StartOut falls.
- Saturation, shift=4: acc_in -37 -> 0x00; 4095 -> 0xFF; 0x7F0 -> 0x7F.
- Rounding, shift=2, acc_in=6:
  - QUANT_ROUND_EN defined -> 0x02.
  - QUANT_ROUND_EN undefined -> 0x01.
- 4-line frame, acc_valid high every cycle -> StartOut high for 64 consecutive cycles with no gap; acc_ready low after 64 accepts.
- 3-line frame, acc_valid drops for 20 cycles after byte 20 -> StartOut falls after 16 bytes, underrun=1, frame_done pulses, remaining input refused.
